// File: rtl/cmd_issuer_if.sv
`default_nettype none
// ============================================================================
//  Module   : cmd_issuer_if
//  Brief    : Command-queue, scoreboard, dispatch and completion signals of
//             the command issuer, bundled with master/slave views.
//  Revision : 1.0
// ============================================================================
interface cmd_issuer_if #(
    parameter int PROC_COUNT = 4,
    parameter int CMD_ID_W   = 8
);
    localparam int CORE_W = $clog2(PROC_COUNT);

    logic                  i_cmd_valid;
    logic                  o_cmd_ready;
    logic [CMD_ID_W-1:0]   i_cmd_id;
    logic [CMD_ID_W-1:0]   i_dep_id;
    logic                  o_sb_read;
    logic                  i_sb_resp;
    logic                  i_sb_exists;
    logic                  o_sb_write;
    logic                  o_sb_flush;
    logic [CMD_ID_W-1:0]   o_sb_id;
    logic [CORE_W-1:0]     o_sb_core;
    logic                  o_disp_valid;
    logic                  i_disp_ready;
    logic [CORE_W-1:0]     o_disp_core;
    logic [CMD_ID_W-1:0]   o_disp_cmd_id;
    logic [PROC_COUNT-1:0] i_done;
    logic [PROC_COUNT-1:0] o_busy;

    modport slave (
        input  i_cmd_valid, i_cmd_id, i_dep_id, i_sb_resp, i_sb_exists,
               i_disp_ready, i_done,
        output o_cmd_ready, o_sb_read, o_sb_write, o_sb_flush, o_sb_id,
               o_sb_core, o_disp_valid, o_disp_core, o_disp_cmd_id, o_busy
    );

    modport master (
        output i_cmd_valid, i_cmd_id, i_dep_id, i_sb_resp, i_sb_exists,
               i_disp_ready, i_done,
        input  o_cmd_ready, o_sb_read, o_sb_write, o_sb_flush, o_sb_id,
               o_sb_core, o_disp_valid, o_disp_core, o_disp_cmd_id, o_busy
    );
endinterface
`default_nettype wire

// File: rtl/cmd_issuer.sv
`default_nettype none
// ============================================================================
//  Module   : cmd_issuer
//  Brief    : Holds one command until its dependency retires, allocates a
//             free core, dispatches, and keeps the scoreboard in step.
//  Revision : 1.0
// ============================================================================
module cmd_issuer #(
    parameter int PROC_COUNT   = 4,
    parameter int CMD_ID_W     = 8,
    parameter int RETRY_CYCLES = 4
) (
    input  wire logic   i_clk,
    input  wire logic   i_rst,
    cmd_issuer_if.slave bus
);
    localparam int CORE_W = $clog2(PROC_COUNT);
    localparam int CNT_W  = (RETRY_CYCLES > 1) ? $clog2(RETRY_CYCLES) : 1;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_LOOKUP   = 3'd1,
        S_WAIT_DEP = 3'd2,
        S_ALLOC    = 3'd3,
        S_DISPATCH = 3'd4,
        S_REGISTER = 3'd5
    } state_t;

    state_t                              state_q, state_d;
    logic [CMD_ID_W-1:0]                 cmd_id_q, cmd_id_d;
    logic [CMD_ID_W-1:0]                 dep_id_q, dep_id_d;
    logic [CORE_W-1:0]                   core_q, core_d;
    logic [CNT_W-1:0]                    cnt_q, cnt_d;
    logic [PROC_COUNT-1:0]               busy_q, busy_d;
    logic [PROC_COUNT-1:0]               pend_q, pend_d;
    logic [PROC_COUNT-1:0][CMD_ID_W-1:0] id_q, id_d;

    logic                  w_flush_any;
    logic [CORE_W-1:0]     w_flush_idx;
    logic [PROC_COUNT-1:0] w_flush_vec;
    logic [PROC_COUNT-1:0] w_avail;
    logic                  w_alloc_ok;
    logic [CORE_W-1:0]     w_alloc_idx;
    logic                  w_disp_hs;
    logic [PROC_COUNT-1:0] w_disp_vec;
    logic [PROC_COUNT-1:0] w_done_eff;
    logic                  w_cmd_ready;
    logic                  w_sb_write;

    // Core bookkeeping: busy map, pending flushes and per-core command ids.
    always_comb begin
        w_flush_any = (pend_q != '0) && (state_q != S_LOOKUP);
        w_flush_idx = '0;
        for (int i = PROC_COUNT - 1; i >= 0; i--) begin
            if (pend_q[i]) w_flush_idx = CORE_W'(i);
        end
        w_flush_vec = w_flush_any ? (PROC_COUNT'(1) << w_flush_idx) : '0;
        // A core whose flush goes out this cycle no longer needs its id reg.
        w_avail     = ~busy_q & ~(pend_q & ~w_flush_vec);
        w_alloc_ok  = (w_avail != '0);
        w_alloc_idx = '0;
        for (int i = PROC_COUNT - 1; i >= 0; i--) begin
            if (w_avail[i]) w_alloc_idx = CORE_W'(i);
        end
        w_disp_hs  = (state_q == S_DISPATCH) && bus.i_disp_ready;
        w_disp_vec = w_disp_hs ? (PROC_COUNT'(1) << core_q) : '0;
        w_done_eff = bus.i_done & busy_q & ~w_disp_vec;
        busy_d     = (busy_q & ~w_done_eff) | w_disp_vec;
        pend_d     = (pend_q & ~w_flush_vec) | w_done_eff;
        id_d       = id_q;
        if (w_disp_hs) id_d[core_q] = cmd_id_q;
    end

    assign w_cmd_ready = (state_q == S_IDLE) && (pend_q == '0) && !i_rst;
    assign w_sb_write  = (state_q == S_REGISTER) && !w_flush_any;

    always_comb begin
        state_d  = state_q;
        cmd_id_d = cmd_id_q;
        dep_id_d = dep_id_q;
        core_d   = core_q;
        cnt_d    = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (bus.i_cmd_valid && w_cmd_ready) begin
                    cmd_id_d = bus.i_cmd_id;
                    dep_id_d = bus.i_dep_id;
                    state_d  = (bus.i_dep_id != '0) ? S_LOOKUP : S_ALLOC;
                end
            end
            S_LOOKUP: begin
                if (bus.i_sb_resp) begin
                    cnt_d   = '0;
                    state_d = bus.i_sb_exists ? S_WAIT_DEP : S_ALLOC;
                end
            end
            S_WAIT_DEP: begin
                if (cnt_q == CNT_W'(RETRY_CYCLES - 1)) state_d = S_LOOKUP;
                else                                   cnt_d   = cnt_q + CNT_W'(1);
            end
            S_ALLOC: begin
                if (w_alloc_ok) begin
                    core_d  = w_alloc_idx;
                    state_d = S_DISPATCH;
                end
            end
            S_DISPATCH: begin
                if (bus.i_disp_ready) state_d = S_REGISTER;
            end
            S_REGISTER: begin
                if (w_sb_write) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q  <= S_IDLE;
            cmd_id_q <= '0;
            dep_id_q <= '0;
            core_q   <= '0;
            cnt_q    <= '0;
            busy_q   <= '0;
            pend_q   <= '0;
            id_q     <= '0;
        end else begin
            state_q  <= state_d;
            cmd_id_q <= cmd_id_d;
            dep_id_q <= dep_id_d;
            core_q   <= core_d;
            cnt_q    <= cnt_d;
            busy_q   <= busy_d;
            pend_q   <= pend_d;
            id_q     <= id_d;
        end
    end

    // Scoreboard key follows the single strobe granted: read > flush > write.
    always_comb begin
        bus.o_sb_id = '0;
        if (state_q == S_LOOKUP) bus.o_sb_id = dep_id_q;
        else if (w_flush_any)    bus.o_sb_id = id_q[w_flush_idx];
        else if (w_sb_write)     bus.o_sb_id = cmd_id_q;
    end

    assign bus.o_cmd_ready   = w_cmd_ready;
    assign bus.o_sb_read     = (state_q == S_LOOKUP);
    assign bus.o_sb_flush    = w_flush_any;
    assign bus.o_sb_write    = w_sb_write;
    assign bus.o_sb_core     = core_q;
    assign bus.o_disp_valid  = (state_q == S_DISPATCH);
    assign bus.o_disp_core   = core_q;
    assign bus.o_disp_cmd_id = cmd_id_q;
    assign bus.o_busy        = busy_q;
endmodule
`default_nettype wire
